record_mode: RTL and testbench
==============================

// Module: record_mode
// PURPOSE
//  Song recorder: samples live keyboard (key_on/key) and writes {note, duration} entries
//  into the 32-entry song memory that the auto-play path later reads back. Sits beside the
//  free-play path; top-level mode mux routes memory write port to it while recording.
//  Terminates every take with an END entry so playback knows where to stop.
// PARAMETERS
//  DEPTH     32        song memory entries (address width = clog2(DEPTH) = 5)
//  DUR_W     26        duration field width, units = clk cycles
//  MIN_DUR   26'd2_000_000  notes/rests shorter than this are discarded (20 ms @100 MHz)
// PORTS
//  clk            in   1      system clock
//  rst            in   1      synchronous reset, active-low
//  rec_start      in   1      1-cycle pulse: begin new take at address 0
//  rec_stop       in   1      1-cycle pulse: end take, write END entry
//  key_on         in   1      a key is held (debounced upstream)
//  key            in   4      held note value 1..14, valid while key_on
//  mem_we         out  1      1-cycle write strobe to song memory
//  mem_addr       out  5      write address
//  mem_note       out  4      note field written
//  mem_duration   out  DUR_W  duration field written
//  recording      out  1      high while take in progress (drives status LED)
//  note_count     out  6      entries written this take, excluding END
//  rec_full       out  1      take ended because memory filled; cleared by rec_start
// BEHAVIOUR
//  Reset (rst==0 at clk edge): all outputs 0, FSM=IDLE, address 0, duration counter 0.
//  Constants: NOTE_REST=4'd0, NOTE_END=4'd15; keys 0/15 on input are ignored (treated as key_on=0).
//  FSM: IDLE -> (rec_start) WAIT; WAIT = armed, no key yet, no time counted;
//   WAIT -> (key_on) NOTE, cur_note<=key, dur<=1; NOTE: dur++ each cycle, saturate at all-ones;
//   NOTE + (key_on==0 or key!=cur_note): close entry; next state GAP (released) or NOTE (new key,
//   cur_note<=key, dur<=1) in the same cycle; GAP: dur++ (saturating) until key_on -> close, NOTE;
//   any state except IDLE + rec_stop -> FIN; FIN writes END, -> IDLE.
//  Closing an entry: if dur>=MIN_DUR, registered write one cycle later: mem_we=1,
//   mem_addr=wr_ptr, mem_note=cur_note (NOTE_REST for gaps), mem_duration=dur; wr_ptr++,
//   note_count++. If dur<MIN_DUR entry dropped, no write, wr_ptr unchanged.
//  Full: when wr_ptr reaches DEPTH-1 after a write, take ends: next cycle write END at DEPTH-1,
//   rec_full<=1, -> IDLE. Max DEPTH-1 real entries; END always present after any take.
//  END entry: mem_note=NOTE_END, mem_duration=0. rec_stop in NOTE/GAP first closes the
//   open entry (MIN_DUR rule applies) then writes END at following address; at most one
//   mem_we per cycle, so close-write and END-write occur on consecutive cycles.
//  rec_stop in WAIT: END written at address 0, note_count=0.
//  rec_start while recording: discard open entry, restart at address 0, rec_full<=0, -> WAIT.
//  rec_start and rec_stop same cycle: rec_stop wins.
//  recording=1 in WAIT/NOTE/GAP/FIN; mem_we never asserted in IDLE except the FIN/full END write.
//  rst mid-take: immediate IDLE, no END written; memory contents left as is.
// CONFIGURATION
//  REC_REST_EN defined: GAP periods >= MIN_DUR recorded as NOTE_REST entries (timing preserved).
//  Not defined: gaps never written; GAP only waits for next key, dur discarded; songs play legato.
// STRUCTURE
//  Shared package song_pkg: NOTE_REST, NOTE_END, DEPTH, DUR_W, entry struct {note, duration}
//   (also used by auto-play memory reader). State enum local.
//  One sub-module: rec_dur_counter (clear/load-1, enable, saturating DUR_W counter, >=MIN_DUR flag).
// TESTING
//  rec_start; key 3 held 3e6 cycles; release; rec_stop -> write {addr0,3,3_000_000}, END@1, count=1.
//  key 5 held 1e6 cycles (<MIN_DUR) then rec_stop -> no note write, END@0, count=0.
//  key 2 3e6 cyc, gap 2.5e6, key 4 3e6 -> with REC_REST_EN: {2},{0,2_500_000},{4},END@3;
//   without: {2},{4},END@2.
//  Key 6 -> key 7 direct change, no release -> two consecutive entries, 7's duration counts from 1.
//  31 valid notes -> after 31st write END@31, rec_full=1, recording=0; further keys ignored.
//  rst low mid-NOTE -> all outputs 0 next cycle, no mem_we; rec_start+rec_stop same cycle -> stop.

Source files
------------

// File: rtl/record_mode_pkg.sv
// song_pkg: song memory constants and entry layout, shared by the recorder
// and the auto-play memory reader.
package song_pkg;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int DUR_W  = 26;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_END  = 4'd15;

  typedef struct packed {
    logic [3:0]       note;
    logic [DUR_W-1:0] duration;
  } song_entry_t;

  // Keys 0 and 15 collide with the REST/END codes, so they count as no key.
  function automatic logic key_valid(input logic key_on, input logic [3:0] key);
    return key_on && (key != NOTE_REST) && (key != NOTE_END);
  endfunction
endpackage

// File: rtl/record_mode_if.sv
// Song memory write port: the recorder drives it (master), the memory takes it (slave).
interface record_mode_if;
  import song_pkg::*;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_note;
  logic [DUR_W-1:0]  mem_duration;

  modport master (output mem_we, output mem_addr, output mem_note, output mem_duration);
  modport slave  (input  mem_we, input  mem_addr, input  mem_note, input  mem_duration);
endinterface

// File: rtl/record_mode_rec_dur_counter.sv
// rec_dur_counter: saturating duration counter for the entry being timed,
// with a flag telling whether it is long enough to keep.
module rec_dur_counter
  import song_pkg::*;
#(
  parameter logic [DUR_W-1:0] MIN_DUR = 26'd2_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load1_i,
  input  logic             en_i,
  output logic [DUR_W-1:0] dur_o,
  output logic             ge_min_o
);
  logic [DUR_W-1:0] dur_q, dur_d;

  // Next count: clear, restart at one, or advance while holding at all-ones.
  always_comb begin
    dur_d = dur_q;
    if (clr_i)
      dur_d = '0;
    else if (load1_i)
      dur_d = DUR_W'(1);
    else if (en_i && (dur_q != '1))
      dur_d = dur_q + DUR_W'(1);
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst)
      dur_q <= '0;
    else
      dur_q <= dur_d;
  end

  assign dur_o    = dur_q;
  assign ge_min_o = (dur_q >= MIN_DUR);
endmodule

// File: rtl/record_mode.sv
// record_mode: records live keyboard notes into song memory as {note, duration}
// entries and closes every take with an END entry.
// Build option: define REC_REST_EN to also record long gaps as REST entries.
module record_mode
  import song_pkg::*;
#(
  parameter logic [DUR_W-1:0] MIN_DUR = 26'd2_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rec_start_i,
  input  logic                rec_stop_i,
  input  logic                key_on_i,
  input  logic [3:0]          key_i,
  record_mode_if.master       mem_wr_o,
  output logic                recording_o,
  output logic [5:0]          note_count_o,
  output logic                rec_full_o
);
`ifdef REC_REST_EN
  localparam bit REST_EN = 1'b1;
`else
  localparam bit REST_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_NOTE, S_GAP, S_FIN} state_t;

  state_t            state_q;
  logic [3:0]        cur_note_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [5:0]        note_count_q;
  logic              rec_full_q, full_pend_q, recording_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  song_entry_t       entry_q;

  logic             key_v, active, stop_c, start_c, note_end, gap_end;
  logic             close_c, write_c, full_c;
  logic             cnt_clr, cnt_load1, cnt_en, ge_min;
  logic [DUR_W-1:0] dur;

  rec_dur_counter #(.MIN_DUR(MIN_DUR)) u_dur (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr),
    .load1_i  (cnt_load1),
    .en_i     (cnt_en),
    .dur_o    (dur),
    .ge_min_o (ge_min)
  );

  // Decode this cycle's events: stop beats start, closing an entry, and counter control.
  always_comb begin
    key_v    = key_valid(key_on_i, key_i);
    active   = (state_q == S_WAIT) || (state_q == S_NOTE) || (state_q == S_GAP);
    stop_c   = active && rec_stop_i;
    start_c  = rec_start_i && !rec_stop_i;
    note_end = (state_q == S_NOTE) && (!key_v || (key_i != cur_note_q));
    gap_end  = (state_q == S_GAP) && key_v;
    close_c  = ((state_q == S_NOTE) || (state_q == S_GAP)) &&
               (stop_c || (!start_c && (note_end || gap_end)));
    write_c  = close_c && ge_min &&
               ((state_q == S_NOTE) || (REST_EN && (state_q == S_GAP)));
    full_c   = write_c && (wr_ptr_q == ADDR_W'(DEPTH - 2));
    cnt_load1 = active && !stop_c && !start_c && !full_c &&
                (((state_q == S_WAIT) && key_v) || note_end || gap_end);
    cnt_en    = active && !stop_c && !start_c &&
                (((state_q == S_NOTE) && !note_end) || ((state_q == S_GAP) && !gap_end));
    cnt_clr   = !cnt_load1 && !cnt_en;
  end

  // Recorder FSM with registered memory-write and status outputs.
  //   state  | meaning
  //   IDLE   | not recording
  //   WAIT   | armed, waiting for first key, no time counted
  //   NOTE   | timing held key cur_note_q
  //   GAP    | timing silence between keys
  //   FIN    | write END entry, then back to IDLE
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cur_note_q   <= '0;
      wr_ptr_q     <= '0;
      note_count_q <= '0;
      rec_full_q   <= 1'b0;
      full_pend_q  <= 1'b0;
      recording_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      entry_q      <= '0;
    end else begin
      mem_we_q <= 1'b0;
      if (write_c) begin
        mem_we_q     <= 1'b1;
        mem_addr_q   <= wr_ptr_q;
        entry_q      <= '{note: (state_q == S_NOTE) ? cur_note_q : NOTE_REST, duration: dur};
        wr_ptr_q     <= wr_ptr_q + ADDR_W'(1);
        note_count_q <= note_count_q + 6'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (start_c) begin
            state_q      <= S_WAIT;
            recording_q  <= 1'b1;
            wr_ptr_q     <= '0;
            note_count_q <= '0;
            rec_full_q   <= 1'b0;
            full_pend_q  <= 1'b0;
          end
        end
        S_FIN: begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= wr_ptr_q;
          entry_q     <= '{note: NOTE_END, duration: '0};
          rec_full_q  <= full_pend_q;
          full_pend_q <= 1'b0;
          recording_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          if (stop_c || full_c) begin
            state_q     <= S_FIN;
            full_pend_q <= full_c;
          end else if (start_c) begin
            // Restart discards the open entry; the write_c path is idle here.
            state_q      <= S_WAIT;
            wr_ptr_q     <= '0;
            note_count_q <= '0;
            rec_full_q   <= 1'b0;
          end else if (((state_q == S_WAIT) && key_v) || gap_end || (note_end && key_v)) begin
            state_q    <= S_NOTE;
            cur_note_q <= key_i;
          end else if (note_end) begin
            state_q <= S_GAP;
          end
        end
      endcase
    end
  end

  assign mem_wr_o.mem_we       = mem_we_q;
  assign mem_wr_o.mem_addr     = mem_addr_q;
  assign mem_wr_o.mem_note     = entry_q.note;
  assign mem_wr_o.mem_duration = entry_q.duration;
  assign recording_o           = recording_q;
  assign note_count_o          = note_count_q;
  assign rec_full_o            = rec_full_q;
endmodule

// File: tb/tb_record_mode.sv
// Testbench for record_mode: directed takes with a scoreboard of expected writes.
// MIN_DUR is scaled down to 20 cycles so every take stays short.
module tb_record_mode;
  import song_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rec_start, rec_stop, key_on;
  logic [3:0] key;
  logic       recording, rec_full;
  logic [5:0] note_count;

  record_mode_if mem_if ();

  record_mode #(.MIN_DUR(26'd20)) dut (
    .clk          (clk),
    .rst          (rst),
    .rec_start_i  (rec_start),
    .rec_stop_i   (rec_stop),
    .key_on_i     (key_on),
    .key_i        (key),
    .mem_wr_o     (mem_if),
    .recording_o  (recording),
    .note_count_o (note_count),
    .rec_full_o   (rec_full)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [3:0]  note;
    logic [25:0] dur;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input int a, input int n, input int d);
    exp_t e;
    e.addr = a[4:0];
    e.note = n[3:0];
    e.dur  = d[25:0];
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int k, input int n);
    key_on = 1'b1;
    key    = k[3:0];
    step(n);
  endtask

  task automatic rel(input int n);
    key_on = 1'b0;
    key    = 4'd0;
    step(n);
  endtask

  task automatic start_take();
    rec_start = 1'b1;
    step(1);
    rec_start = 1'b0;
  endtask

  task automatic stop_take();
    rec_stop = 1'b1;
    step(1);
    rec_stop = 1'b0;
    step(3);
  endtask

  // Every write strobe is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (mem_if.mem_we === 1'b1) begin
      exp_t e;
      e = '{addr: 5'bx, note: 4'bx, dur: 26'bx};
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check("wr_addr", mem_if.mem_addr, e.addr);
      check("wr_note", mem_if.mem_note, e.note);
      check("wr_dur",  mem_if.mem_duration, e.dur);
    end
  end

  initial begin
    rst = 1'b0; rec_start = 1'b0; rec_stop = 1'b0; key_on = 1'b0; key = 4'd0;
    step(3);
    check("rst_we",    mem_if.mem_we, 0);
    check("rst_addr",  mem_if.mem_addr, 0);
    check("rst_note",  mem_if.mem_note, 0);
    check("rst_dur",   mem_if.mem_duration, 0);
    check("rst_rec",   recording, 0);
    check("rst_count", note_count, 0);
    check("rst_full",  rec_full, 0);
    rst = 1'b1;
    step(2);

    // Take 1: one long note, then stop.
    start_take();
    check("t1_recording", recording, 1);
    press(3, 30);
    expect_wr(0, 3, 30);
    rel(5);
    expect_wr(1, NOTE_END, 0);
    stop_take();
    check("t1_count", note_count, 1);
    check("t1_rec_off", recording, 0);
    check("t1_full", rec_full, 0);
    check("t1_drained", exp_q.size(), 0);

    // Take 2: short note dropped, stop while still held.
    start_take();
    press(5, 10);
    expect_wr(0, NOTE_END, 0);
    stop_take();
    rel(2);
    check("t2_count", note_count, 0);
    check("t2_drained", exp_q.size(), 0);

    // Take 3: note, long gap, note.
    start_take();
    press(2, 30);
    expect_wr(0, 2, 30);
    rel(25);
`ifdef REC_REST_EN
    expect_wr(1, NOTE_REST, 25);
    press(4, 30);
    expect_wr(2, 4, 30);
    rel(3);
    expect_wr(3, NOTE_END, 0);
    stop_take();
    check("t3_count", note_count, 3);
`else
    press(4, 30);
    expect_wr(1, 4, 30);
    rel(3);
    expect_wr(2, NOTE_END, 0);
    stop_take();
    check("t3_count", note_count, 2);
`endif
    check("t3_drained", exp_q.size(), 0);

    // Take 4: direct key change, second duration starts at 1.
    start_take();
    press(6, 30);
    expect_wr(0, 6, 30);
    press(7, 25);
    expect_wr(1, 7, 25);
    rel(3);
    expect_wr(2, NOTE_END, 0);
    stop_take();
    check("t4_count", note_count, 2);
    check("t4_drained", exp_q.size(), 0);

    // Take 5: exactly MIN_DUR kept, one cycle short dropped.
    start_take();
    press(8, 20);
    expect_wr(0, 8, 20);
    press(9, 19);
    rel(3);
    expect_wr(1, NOTE_END, 0);
    stop_take();
    check("t5_count", note_count, 1);
    check("t5_drained", exp_q.size(), 0);

    // Take 6: fill memory with 31 notes; END lands at 31 and the take ends.
    start_take();
    for (int i = 0; i < 31; i++) begin
      press((i % 14) + 1, 20);
      expect_wr(i, (i % 14) + 1, 20);
    end
    expect_wr(31, NOTE_END, 0);
    rel(4);
    check("t6_full", rec_full, 1);
    check("t6_rec_off", recording, 0);
    check("t6_count", note_count, 31);
    press(3, 30);
    rel(5);
    check("t6_drained", exp_q.size(), 0);

    // rec_start clears rec_full; immediate stop gives END at 0.
    start_take();
    check("t7_full_clr", rec_full, 0);
    check("t7_recording", recording, 1);
    check("t7_count", note_count, 0);
    expect_wr(0, NOTE_END, 0);
    stop_take();
    check("t7_drained", exp_q.size(), 0);

    // Reset in the middle of a note: outputs cleared, no END written.
    start_take();
    press(3, 30);
    rst = 1'b0;
    step(1);
    check("t8_we",    mem_if.mem_we, 0);
    check("t8_rec",   recording, 0);
    check("t8_count", note_count, 0);
    check("t8_full",  rec_full, 0);
    check("t8_addr",  mem_if.mem_addr, 0);
    rel(2);
    rst = 1'b1;
    step(5);
    check("t8_drained", exp_q.size(), 0);

    // rec_start and rec_stop together while recording: stop wins.
    start_take();
    press(3, 30);
    expect_wr(0, 3, 30);
    expect_wr(1, NOTE_END, 0);
    rec_start = 1'b1;
    rec_stop  = 1'b1;
    step(1);
    rec_start = 1'b0;
    rec_stop  = 1'b0;
    rel(4);
    check("t9_rec_off", recording, 0);
    check("t9_count", note_count, 1);
    check("t9_drained", exp_q.size(), 0);

    // rec_start mid-note discards the open entry and restarts at address 0.
    start_take();
    press(5, 30);
    rec_start = 1'b1;
    step(1);
    rec_start = 1'b0;
    press(5, 20);
    expect_wr(0, 5, 20);
    rel(3);
    expect_wr(1, NOTE_END, 0);
    stop_take();
    check("t10_count", note_count, 1);
    check("t10_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
